nway_cache: RTL and testbench
=============================

# nway_cache

Parametrised N-way set-associative, write-back, write-allocate cache, the successor to the fixed 2-way/256-set/16-byte-line cache. It sits between the CPU pipeline's memory stage and the AXI bridge, presenting the same CPU request/response and bridge read/write handshakes. It adds:
- configurable ways, sets and line length;
- per-set round-robin replacement;
- uncached single-word accesses that bypass the arrays.

## Interface
- WAYS, 2, associativity; power of two, 1..8
- SETS, 256, sets per way; power of two
- LINE_WORDS, 4, 32-bit words per line; power of two, 2..16
- Derived: IDX_W=log2(SETS), OFF_W=log2(LINE_WORDS)+2, TAG_W=32-IDX_W-OFF_W
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- valid  in  1  CPU request
- op  in  1  1=write, 0=read
- uncached  in  1  bypass cache for this request
- addr  in  32  physical byte address
- wstrb  in  4  byte enables (write)
- wdata  in  32  write data
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  read data valid / write complete
- rdata  out  32  read data
- rd_req  out  1  bridge read request
- rd_type  out  3  3'b100 line, 3'b010 word
- rd_addr  out  32  read address
- rd_rdy  in  1  read request accepted
- ret_valid  in  1  return beat valid
- ret_last  in  1  final beat
- ret_data  in  32  return data
- wr_req  out  1  bridge write request
- wr_type  out  3  3'b100 line, 3'b010 word
- wr_addr  out  32  write address
- wr_wstrb  out  4  byte enables (word writes); 4'hf for lines
- wr_data  out  32*LINE_WORDS  write data; word writes use bits [31:0]
- wr_rdy  in  1  write request accepted

## Operation
- Storage:
  - Per way: tag array (TAG_W) and data array (LINE_WORDS×32) with synchronous 1-cycle read.
  - V and D bits: flop arrays, WAYS×SETS, cleared by rst.
  - Per-set round-robin pointer: log2(WAYS) bits, reset 0.
- Blocking design: one request in flight.
- Request buffer captures op/uncached/addr/wstrb/wdata on addr_ok.
- FSM states: IDLE, LOOKUP, MISS, REPLACE, REFILL, UREQ, URESP.
- IDLE:
  - addr_ok=valid.
  - On valid&~uncached: arrays read at addr index; go LOOKUP.
  - On valid&uncached: go UREQ.
- LOOKUP: hit = any way with V=1 and tag match (at most one).
  - Read hit: data_ok=1, rdata = hit word. Go IDLE.
  - Write hit: hit word is byte-merged with wstrb and written at end of cycle; D=1; data_ok=1. Go IDLE.
  - Miss:
    - victim = round-robin pointer of the set.
    - Victim line and tag are latched into the write buffer.
    - Go MISS.
- MISS:
  - If victim V&D: wr_req=1, wr_type=3'b100, wr_addr={victim tag, index, 0}, wr_data = latched line. Hold until wr_rdy, then go REPLACE.
  - Else go REPLACE next cycle with no write.
- REPLACE: rd_req=1, rd_type=3'b100, rd_addr = line-aligned addr. On rd_rdy go REFILL.
- REFILL:
  - Beat counter starts at 0. Each ret_valid writes word[cnt] of the victim way and cnt++.
  - On the beat where cnt == requested word:
    - Write request: ret_data is merged with wdata under wstrb before storing.
    - data_ok=1; rdata=ret_data (read).
  - On ret_valid&ret_last:
    - Write tag, V=1, D=op.
    - Set pointer advances (wraps at WAYS-1).
    - Go IDLE.
- UREQ:
  - Read: rd_req=1, rd_type=3'b010, rd_addr=addr. On rd_rdy go URESP.
  - Write: wr_req=1, wr_type=3'b010, wr_addr=addr, wr_wstrb=wstrb, wr_data[31:0]=wdata. On wr_rdy: data_ok=1, go IDLE.
- URESP: on ret_valid: data_ok=1, rdata=ret_data, go IDLE.
- Uncached accesses never read, modify or allocate cache lines.

## Timing
- Reset values: all outputs 0 except rd_type/wr_type=3'b100, wr_wstrb=4'hf. State IDLE; all V/D=0; pointers 0.
- Hit latency: addr_ok at cycle T, data_ok at T+1. Next request is accepted at T+2 earliest; addr_ok is low outside IDLE.
- Clean miss: MISS 1 cycle, then REPLACE until rd_rdy. Requested word returns data_ok on its beat (critical word not reordered).
- Request hold rules:
  - rd_req/wr_req and their address/data/type stay stable until the matching rdy.
  - wr_req and rd_req are never asserted in the same cycle.
- A write hit's array update is visible to the request accepted in the following IDLE cycle.
- ret_valid outside REFILL/URESP is ignored.
- rst mid-transaction:
  - FSM returns to IDLE and outstanding requests drop.
  - All lines are invalidated; the bridge is reset in the same domain.
- WAYS=1: pointer is constant 0; every miss replaces way 0.

## Test plan
- Cold read miss:
  - Stimulus: read 0x0000_1004 on an empty cache (WAYS=2, LINE_WORDS=4).
  - Required: rd_req with rd_addr=0x0000_1000, type 3'b100. Beats 0xA0..0xA3 return; data_ok on beat 1 with rdata=0xA1.
  - Re-read 0x1004: hit, data_ok at T+1, rdata=0xA1, no rd_req.
- Write hit then read:
  - Stimulus: write 0x1008, wstrb=4'b0011, wdata=0xFFFF_5555 over line word 0xA2; then read 0x1008.
  - Required: rdata=0x0000_5555 (upper bytes of 0xA2, lower two bytes from wdata); line now dirty.
- Dirty eviction:
  - Stimulus: fill both ways of set 0x00 (write to way 0), then miss on a third tag in that set.
  - Required: wr_req with wr_type 3'b100 and the dirty line's address/data before rd_req. Pointer selects way 0, then way 1 on the next miss.
- Uncached:
  - Read 0xBFD0_0010: rd_type 3'b010, rd_addr exact, rdata=ret_data.
  - Write wstrb=4'b1000: wr_type 3'b010, wr_wstrb=4'b1000.
  - Neither touches V bits.
- Backpressure:
  - Stimulus: hold rd_rdy/wr_rdy low for 5 cycles.
  - Required: requests and address/data held stable; no extra data_ok.
- Reset in REFILL:
  - Stimulus: assert rst after beat 2.
  - Required: next cycle IDLE, all outputs at reset values; a re-read of the same address misses.

Source files
------------

// File: rtl/nway_cache.sv
// nway_cache: N-way set-associative, write-back, write-allocate cache with
// per-set round-robin replacement and uncached single-word bypass.
// One request is in flight at a time.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid/op/uncached/addr/wstrb/wdata   CPU request (op=1 write)
//   addr_ok/data_ok/rdata                CPU handshake and read data
//   rd_req/rd_type/rd_addr/rd_rdy        bridge read request
//   ret_valid/ret_last/ret_data          bridge read return beats
//   wr_req/wr_type/wr_addr/wr_wstrb/wr_data/wr_rdy  bridge write request
module nway_cache #(
  parameter int WAYS       = 2,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic                      op,
  input  logic                      uncached,
  input  logic [31:0]               addr,
  input  logic [3:0]                wstrb,
  input  logic [31:0]               wdata,
  output logic                      addr_ok,
  output logic                      data_ok,
  output logic [31:0]               rdata,
  output logic                      rd_req,
  output logic [2:0]                rd_type,
  output logic [31:0]               rd_addr,
  input  logic                      rd_rdy,
  input  logic                      ret_valid,
  input  logic                      ret_last,
  input  logic [31:0]               ret_data,
  output logic                      wr_req,
  output logic [2:0]                wr_type,
  output logic [31:0]               wr_addr,
  output logic [3:0]                wr_wstrb,
  output logic [32*LINE_WORDS-1:0]  wr_data,
  input  logic                      wr_rdy
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_W = 32 * LINE_WORDS;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REPLACE, REFILL, UREQ, URESP} state_t;

  state_t            state_q, state_d;
  logic              req_op_q, req_op_d;
  logic              req_unc_q, req_unc_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic [3:0]        req_wstrb_q, req_wstrb_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [WAY_W-1:0]  victim_q, victim_d;
  logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;
  logic [LINE_W-1:0] wb_line_q, wb_line_d;
  logic              wb_dirty_q, wb_dirty_d;
  logic [WOFF_W-1:0] cnt_q, cnt_d;
  logic [SETS-1:0]   v_q [WAYS];
  logic [SETS-1:0]   v_d [WAYS];
  logic [SETS-1:0]   d_q [WAYS];
  logic [SETS-1:0]   d_d [WAYS];
  logic [WAY_W-1:0]  ptr_q [SETS];
  logic [WAY_W-1:0]  ptr_d [SETS];

  logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
  logic [LINE_W-1:0] data_mem  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_rd_q  [WAYS];
  logic [LINE_W-1:0] data_rd_q [WAYS];

  logic              tag_we, data_we;
  logic [WAY_W-1:0]  mem_way;
  logic [WOFF_W-1:0] data_word;
  logic [31:0]       data_val;

  logic [IDX_W-1:0]  in_idx, req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WOFF_W-1:0] req_word;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, rr_way;
  logic [31:0]       hit_word;

  assign in_idx   = addr[OFF_W +: IDX_W];
  assign req_idx  = req_addr_q[OFF_W +: IDX_W];
  assign req_tag  = req_addr_q[31 -: TAG_W];
  assign req_word = req_addr_q[2 +: WOFF_W];
  assign rr_way   = ptr_q[req_idx];

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  // Tag compare against the arrays read during IDLE; at most one way matches.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (v_q[w][req_idx] && (tag_rd_q[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    hit_word = data_rd_q[hit_way][32*int'(req_word) +: 32];
  end

  // Arrays are read only while IDLE so the LOOKUP cycle sees the line of the
  // request just accepted; writes come from write hits and refill beats.
  always_ff @(posedge clk) begin
    if (state_q == IDLE) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_rd_q[w]  <= tag_mem[w][in_idx];
        data_rd_q[w] <= data_mem[w][in_idx];
      end
    end
    if (tag_we) begin
      tag_mem[mem_way][req_idx] <= req_tag;
    end
    if (data_we) begin
      data_mem[mem_way][req_idx][32*int'(data_word) +: 32] <= data_val;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_op_d    = req_op_q;
    req_unc_d   = req_unc_q;
    req_addr_d  = req_addr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    wb_tag_d    = wb_tag_q;
    wb_line_d   = wb_line_q;
    wb_dirty_d  = wb_dirty_q;
    cnt_d       = cnt_q;
    v_d         = v_q;
    d_d         = d_q;
    ptr_d       = ptr_q;
    addr_ok     = 1'b0;
    data_ok     = 1'b0;
    rdata       = '0;
    rd_req      = 1'b0;
    rd_type     = 3'b100;
    rd_addr     = '0;
    wr_req      = 1'b0;
    wr_type     = 3'b100;
    wr_addr     = '0;
    wr_wstrb    = 4'hf;
    wr_data     = '0;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    mem_way     = victim_q;
    data_word   = cnt_q;
    data_val    = ret_data;
    case (state_q)
      IDLE: begin
        addr_ok = valid;
        if (valid) begin
          req_op_d    = op;
          req_unc_d   = uncached;
          req_addr_d  = addr;
          req_wstrb_d = wstrb;
          req_wdata_d = wdata;
          state_d     = uncached ? UREQ : LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          data_ok = 1'b1;
          state_d = IDLE;
          if (req_op_q) begin
            data_we               = 1'b1;
            mem_way               = hit_way;
            data_word             = req_word;
            data_val              = merge_bytes(hit_word, req_wdata_q, req_wstrb_q);
            d_d[hit_way][req_idx] = 1'b1;
          end else begin
            rdata = hit_word;
          end
        end else begin
          // Snapshot the victim now: refill overwrites it word by word.
          victim_d   = rr_way;
          wb_tag_d   = tag_rd_q[rr_way];
          wb_line_d  = data_rd_q[rr_way];
          wb_dirty_d = v_q[rr_way][req_idx] & d_q[rr_way][req_idx];
          state_d    = MISS;
        end
      end
      MISS: begin
        if (wb_dirty_q) begin
          wr_req  = 1'b1;
          wr_addr = {wb_tag_q, req_idx, {OFF_W{1'b0}}};
          wr_data = wb_line_q;
          if (wr_rdy) begin
            state_d = REPLACE;
          end
        end else begin
          state_d = REPLACE;
        end
      end
      REPLACE: begin
        rd_req  = 1'b1;
        rd_addr = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
        if (rd_rdy) begin
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        if (ret_valid) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == req_word) begin
            data_ok = 1'b1;
            if (req_op_q) begin
              data_val = merge_bytes(ret_data, req_wdata_q, req_wstrb_q);
            end else begin
              rdata = ret_data;
            end
          end
          if (ret_last) begin
            tag_we                 = 1'b1;
            v_d[victim_q][req_idx] = 1'b1;
            d_d[victim_q][req_idx] = req_op_q;
            ptr_d[req_idx]         = (ptr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                          : ptr_q[req_idx] + 1'b1;
            state_d                = IDLE;
          end
        end
      end
      UREQ: begin
        if (req_op_q) begin
          wr_req        = 1'b1;
          wr_type       = 3'b010;
          wr_addr       = req_addr_q;
          wr_wstrb      = req_wstrb_q;
          wr_data[31:0] = req_wdata_q;
          if (wr_rdy) begin
            data_ok = 1'b1;
            state_d = IDLE;
          end
        end else begin
          rd_req  = 1'b1;
          rd_type = 3'b010;
          rd_addr = req_addr_q;
          if (rd_rdy) begin
            state_d = URESP;
          end
        end
      end
      URESP: begin
        if (ret_valid) begin
          data_ok = 1'b1;
          rdata   = ret_data;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_op_q    <= 1'b0;
      req_unc_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
      victim_q    <= '0;
      wb_tag_q    <= '0;
      wb_line_q   <= '0;
      wb_dirty_q  <= 1'b0;
      cnt_q       <= '0;
      for (int w = 0; w < WAYS; w++) begin
        v_q[w] <= '0;
        d_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) begin
        ptr_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      req_op_q    <= req_op_d;
      req_unc_q   <= req_unc_d;
      req_addr_q  <= req_addr_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      wb_tag_q    <= wb_tag_d;
      wb_line_q   <= wb_line_d;
      wb_dirty_q  <= wb_dirty_d;
      cnt_q       <= cnt_d;
      v_q         <= v_d;
      d_q         <= d_d;
      ptr_q       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_nway_cache.sv
// tb_nway_cache: directed self-checking bench for nway_cache
// (WAYS=2, SETS=256, LINE_WORDS=4). The bench plays the bridge by hand,
// driving inputs just after the falling edge and sampling 1 ns later.
module tb_nway_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid, op, uncached;
  logic [31:0]  addr, wdata;
  logic [3:0]   wstrb;
  logic         addr_ok, data_ok;
  logic [31:0]  rdata;
  logic         rd_req;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;
  logic         wr_req;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic         wr_rdy;

  int numChecks = 0;
  int numErrors = 0;

  always #5 clk = ~clk;

  nway_cache #(.WAYS(2), .SETS(256), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .op(op), .uncached(uncached),
    .addr(addr), .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type),
    .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_last(ret_last), .ret_data(ret_data), .wr_req(wr_req),
    .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One CPU request: present it in IDLE, then drop valid in the next cycle.
  task automatic applyStimulus(input logic isWrite, input logic isUnc,
                               input logic [31:0] a, input logic [3:0] s,
                               input logic [31:0] d);
    @(negedge clk);
    valid = 1'b1; op = isWrite; uncached = isUnc; addr = a; wstrb = s; wdata = d;
    #1 checkOutput("addr_ok", addr_ok, 1'b1);
    @(negedge clk);
    valid = 1'b0; op = 1'b0; uncached = 1'b0; addr = '0; wstrb = '0; wdata = '0;
    #1;
  endtask

  // Advance one cycle with the given bridge inputs.
  task automatic nextCycle(input logic rr, input logic wr, input logic rv,
                           input logic rl, input logic [31:0] rd);
    @(negedge clk);
    rd_rdy = rr; wr_rdy = wr; ret_valid = rv; ret_last = rl; ret_data = rd;
    #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst addr_ok", addr_ok, 1'b0);
    checkOutput("rst data_ok", data_ok, 1'b0);
    checkOutput("rst rdata", rdata, 32'h0);
    checkOutput("rst rd_req", rd_req, 1'b0);
    checkOutput("rst rd_type", rd_type, 3'b100);
    checkOutput("rst rd_addr", rd_addr, 32'h0);
    checkOutput("rst wr_req", wr_req, 1'b0);
    checkOutput("rst wr_type", wr_type, 3'b100);
    checkOutput("rst wr_addr", wr_addr, 32'h0);
    checkOutput("rst wr_wstrb", wr_wstrb, 4'hf);
    checkOutput("rst wr_data", wr_data, 128'h0);
  endtask

  // Called in the REPLACE cycle: line read held under backpressure, then accepted.
  task automatic replaceAccept(input logic [31:0] lineAddr);
    checkOutput("replace rd_req", rd_req, 1'b1);
    checkOutput("replace rd_type", rd_type, 3'b100);
    checkOutput("replace rd_addr", rd_addr, lineAddr);
    checkOutput("replace wr_req", wr_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("rd hold rd_req", rd_req, 1'b1);
      checkOutput("rd hold rd_addr", rd_addr, lineAddr);
      checkOutput("rd hold data_ok", data_ok, 1'b0);
    end
    nextCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Called in the LOOKUP cycle of a miss whose victim is clean.
  task automatic missClean(input logic [31:0] lineAddr);
    checkOutput("miss data_ok", data_ok, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("clean miss wr_req", wr_req, 1'b0);
    checkOutput("clean miss rd_req", rd_req, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    replaceAccept(lineAddr);
  endtask

  // Four return beats base+0..base+3; data_ok only on the requested word.
  task automatic refillLine(input logic [31:0] base, input int reqWord, input logic isRead);
    for (int i = 0; i < 4; i++) begin
      nextCycle(1'b0, 1'b0, 1'b1, (i == 3), base + i);
      checkOutput("refill data_ok", data_ok, (i == reqWord));
      if (i == reqWord && isRead) checkOutput("refill rdata", rdata, base + i);
    end
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after refill rd_req", rd_req, 1'b0);
    checkOutput("after refill data_ok", data_ok, 1'b0);
  endtask

  task automatic expectHit(input logic [31:0] a, input logic [31:0] expData);
    applyStimulus(1'b0, 1'b0, a, 4'h0, 32'h0);
    checkOutput("hit data_ok", data_ok, 1'b1);
    checkOutput("hit rdata", rdata, expData);
    checkOutput("hit rd_req", rd_req, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; valid = 1'b0; op = 1'b0; uncached = 1'b0; addr = '0;
    wstrb = '0; wdata = '0; rd_rdy = 1'b0; ret_valid = 1'b0;
    ret_last = 1'b0; ret_data = '0; wr_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 checkResetValues();

    // Cold read miss on 0x1004, line A0..A3, word 1 requested.
    applyStimulus(1'b0, 1'b0, 32'h0000_1004, 4'h0, 32'h0);
    missClean(32'h0000_1000);
    refillLine(32'hA0, 1, 1'b1);
    expectHit(32'h0000_1004, 32'hA1);

    // Write hit merges low half into A2, then read it back.
    applyStimulus(1'b1, 1'b0, 32'h0000_1008, 4'b0011, 32'hFFFF_5555);
    checkOutput("write hit data_ok", data_ok, 1'b1);
    checkOutput("write hit rd_req", rd_req, 1'b0);
    expectHit(32'h0000_1008, 32'h0000_5555);

    // Fill way 1 of set 0 with tag 2.
    applyStimulus(1'b0, 1'b0, 32'h0000_2000, 4'h0, 32'h0);
    missClean(32'h0000_2000);
    refillLine(32'hB0, 0, 1'b1);

    // Third tag evicts dirty way 0: line write first, held 5 cycles.
    applyStimulus(1'b0, 1'b0, 32'h0000_3004, 4'h0, 32'h0);
    checkOutput("dirty miss data_ok", data_ok, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("evict wr_req", wr_req, 1'b1);
    checkOutput("evict wr_type", wr_type, 3'b100);
    checkOutput("evict wr_addr", wr_addr, 32'h0000_1000);
    checkOutput("evict wr_data", wr_data, 128'h000000A3_00005555_000000A1_000000A0);
    checkOutput("evict rd_req", rd_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("wr hold wr_req", wr_req, 1'b1);
      checkOutput("wr hold wr_addr", wr_addr, 32'h0000_1000);
      checkOutput("wr hold wr_data", wr_data, 128'h000000A3_00005555_000000A1_000000A0);
      checkOutput("wr hold rd_req", rd_req, 1'b0);
      checkOutput("wr hold data_ok", data_ok, 1'b0);
    end
    nextCycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("evict accept wr_req", wr_req, 1'b1);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after evict wr_req", wr_req, 1'b0);
    replaceAccept(32'h0000_3000);
    refillLine(32'hC0, 1, 1'b1);

    // Next miss in set 0 must replace way 1 (tag 2), keeping tag 3.
    applyStimulus(1'b0, 1'b0, 32'h0000_4000, 4'h0, 32'h0);
    missClean(32'h0000_4000);
    refillLine(32'hD0, 0, 1'b1);
    expectHit(32'h0000_3004, 32'hC1);
    expectHit(32'h0000_4000, 32'hD0);

    // Uncached read.
    applyStimulus(1'b0, 1'b1, 32'hBFD0_0010, 4'h0, 32'h0);
    checkOutput("ucrd rd_req", rd_req, 1'b1);
    checkOutput("ucrd rd_type", rd_type, 3'b010);
    checkOutput("ucrd rd_addr", rd_addr, 32'hBFD0_0010);
    checkOutput("ucrd wr_req", wr_req, 1'b0);
    nextCycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ucrd accept data_ok", data_ok, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    checkOutput("ucrd data_ok", data_ok, 1'b1);
    checkOutput("ucrd rdata", rdata, 32'h1234_5678);
    checkOutput("ucrd rd_req", rd_req, 1'b0);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ucrd done data_ok", data_ok, 1'b0);

    // Uncached write with backpressure.
    applyStimulus(1'b1, 1'b1, 32'hBFD0_0020, 4'b1000, 32'hAB00_0000);
    for (int i = 0; i < 3; i++) begin
      checkOutput("ucwr wr_req", wr_req, 1'b1);
      checkOutput("ucwr wr_type", wr_type, 3'b010);
      checkOutput("ucwr wr_addr", wr_addr, 32'hBFD0_0020);
      checkOutput("ucwr wr_wstrb", wr_wstrb, 4'b1000);
      checkOutput("ucwr wr_data", wr_data, 128'hAB00_0000);
      checkOutput("ucwr rd_req", rd_req, 1'b0);
      checkOutput("ucwr data_ok", data_ok, 1'b0);
      nextCycle(1'b0, (i == 2), 1'b0, 1'b0, 32'h0);
    end
    checkOutput("ucwr accept data_ok", data_ok, 1'b1);
    nextCycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ucwr done wr_req", wr_req, 1'b0);
    checkOutput("ucwr done data_ok", data_ok, 1'b0);
    expectHit(32'h0000_3004, 32'hC1);

    // Reset during refill after the requested beat.
    applyStimulus(1'b0, 1'b0, 32'h0000_5008, 4'h0, 32'h0);
    missClean(32'h0000_5000);
    for (int i = 0; i < 3; i++) begin
      nextCycle(1'b0, 1'b0, 1'b1, 1'b0, 32'hE0 + i);
      checkOutput("partial data_ok", data_ok, (i == 2));
    end
    checkOutput("partial rdata", rdata, 32'hE2);
    @(negedge clk);
    rst = 1'b1; ret_valid = 1'b0; ret_data = '0;
    @(negedge clk);
    rst = 1'b0;
    #1 checkResetValues();
    applyStimulus(1'b0, 1'b0, 32'h0000_5008, 4'h0, 32'h0);
    missClean(32'h0000_5000);
    refillLine(32'hF0, 2, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0000_3004, 4'h0, 32'h0);
    checkOutput("post-rst miss data_ok", data_ok, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
